// File: rtl/conv_window_stream.sv
// conv_window_stream: streaming K x K x C sliding-window generator with internal zero padding.
// Optional macro CONV_WIN_POS_EN adds out_row/out_col output-map coordinates.
module conv_window_stream #(
  parameter int pDATA_WIDTH   = 8,
  parameter int pIN_CHANNEL   = 1,
  parameter int pINPUT_WIDTH  = 28,
  parameter int pINPUT_HEIGHT = 28,
  parameter int pKERNEL_SIZE  = 3,
  parameter int pPADDING      = 1,
  parameter int pSTRIDE       = 1
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         start,
  input  logic                                                         in_valid,
  input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]                           in_data,
  output logic                                                         in_ready,
  output logic                                                         out_valid,
  input  logic                                                         out_ready,
  output logic [pDATA_WIDTH*pIN_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] out_data,
  output logic                                                         out_last,
  output logic                                                         busy,
  output logic                                                         done
`ifdef CONV_WIN_POS_EN
  ,
  output logic [15:0]                                                  out_row,
  output logic [15:0]                                                  out_col
`endif
);
  localparam int CW = pDATA_WIDTH * pIN_CHANNEL;
  localparam int K  = pKERNEL_SIZE;
  localparam int WP = pINPUT_WIDTH + 2 * pPADDING;
  localparam int HP = pINPUT_HEIGHT + 2 * pPADDING;
  localparam int OW = (WP - K) / pSTRIDE + 1;
  localparam int OH = (HP - K) / pSTRIDE + 1;
  localparam int AW = (WP > 1) ? $clog2(WP) : 1;
  localparam int LW = (K > 1) ? (K - 1) * CW : CW;

  localparam logic [15:0] WP_M1   = 16'(WP - 1);
  localparam logic [15:0] HP_M1   = 16'(HP - 1);
  localparam logic [15:0] K_M1    = 16'(K - 1);
  localparam logic [15:0] PAD     = 16'(pPADDING);
  localparam logic [15:0] COL_END = 16'(pPADDING + pINPUT_WIDTH);
  localparam logic [15:0] ROW_END = 16'(pPADDING + pINPUT_HEIGHT);
  localparam logic [15:0] STRIDE  = 16'(pSTRIDE);
  localparam logic [15:0] OW_M1   = 16'(OW - 1);
  localparam logic [15:0] OH_M1   = 16'(OH - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t              state_r, state_nx_s;
  logic [15:0]         pr_r, pc_r;
  logic                last_seen_r, out_valid_r, out_last_r;
  logic [CW*K*K-1:0]   win_r, win_nx_s, out_data_r;
  logic [CW*K-1:0]     col_s;
  logic [LW-1:0]       lout_s;
  logic [CW-1:0]       push_s;
  logic [AW-1:0]       col_idx_s;
  logic [15:0]         rdiff_s, cdiff_s, orow_s, ocol_s;
  logic                interior_s, stall_s, step_s, final_step_s;
  logic                hs_s, last_hs_s, emit_s, last_win_s;

  assign interior_s   = (pr_r >= PAD) && (pr_r < ROW_END) && (pc_r >= PAD) && (pc_r < COL_END);
  assign stall_s      = out_valid_r && !out_ready;
  assign step_s       = (state_r == ST_SCAN) && !stall_s && (!interior_s || in_valid);
  assign in_ready     = (state_r == ST_SCAN) && interior_s && !stall_s;
  assign push_s       = interior_s ? in_data : {CW{1'b0}};
  assign final_step_s = step_s && (pr_r == HP_M1) && (pc_r == WP_M1);
  assign hs_s         = out_valid_r && out_ready;
  assign last_hs_s    = hs_s && out_last_r;
  assign col_idx_s    = pc_r[AW-1:0];

  // The window being completed by this step has top-left (pr-K+1, pc-K+1).
  assign rdiff_s    = pr_r - K_M1;
  assign cdiff_s    = pc_r - K_M1;
  assign orow_s     = rdiff_s / STRIDE;
  assign ocol_s     = cdiff_s / STRIDE;
  assign emit_s     = (pr_r >= K_M1) && (pc_r >= K_M1) &&
                      ((rdiff_s % STRIDE) == 16'd0) && ((cdiff_s % STRIDE) == 16'd0) &&
                      (orow_s <= OH_M1) && (ocol_s <= OW_M1);
  assign last_win_s = emit_s && (orow_s == OH_M1) && (ocol_s == OW_M1);

  generate
    if (K > 1) begin : g_lines
      for (genvar l = 0; l < K - 1; l++) begin : g_line
        logic [CW-1:0] mem_r [WP];
        logic [CW-1:0] wr_s;
        if (l == 0) begin : g_first
          assign wr_s = push_s;
        end else begin : g_next
          assign wr_s = lout_s[(l-1)*CW +: CW];
        end
        // Each line pushes its old pixel at this column down to the next older line.
        always_ff @(posedge clk) begin
          if (step_s) mem_r[col_idx_s] <= wr_s;
        end
        assign lout_s[l*CW +: CW] = mem_r[col_idx_s];
      end
      for (genvar g = 0; g < K - 1; g++) begin : g_col
        assign col_s[g*CW +: CW] = lout_s[(K-2-g)*CW +: CW];
      end
    end else begin : g_nolines
      assign lout_s = {LW{1'b0}};
    end
  endgenerate
  assign col_s[(K-1)*CW +: CW] = push_s;

  // Window shifts left one column; the new right column is oldest line on top.
  always_comb begin
    win_nx_s = win_r;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K - 1; kc++) begin
        win_nx_s[(kr*K+kc)*CW +: CW] = win_r[(kr*K+kc+1)*CW +: CW];
      end
      win_nx_s[(kr*K+K-1)*CW +: CW] = col_s[kr*CW +: CW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nx_s;
  end

  // Next state; with stride > 1 the last window may have left before the final step.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_SCAN;
        else       state_nx_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (final_step_s) begin
          if (last_seen_r || last_hs_s) state_nx_s = ST_IDLE;
          else                          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (last_hs_s) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Padded scan coordinates and the last-window-accepted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_r        <= 16'd0;
      pc_r        <= 16'd0;
      last_seen_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        pr_r        <= 16'd0;
        pc_r        <= 16'd0;
        last_seen_r <= 1'b0;
      end
    end else begin
      if (last_hs_s) last_seen_r <= 1'b1;
      if (step_s) begin
        if (pc_r == WP_M1) begin
          pc_r <= 16'd0;
          pr_r <= pr_r + 16'd1;
        end else begin
          pc_r <= pc_r + 16'd1;
        end
      end
    end
  end

  // Window register and the output holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r       <= {(CW*K*K){1'b0}};
      out_data_r  <= {(CW*K*K){1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      if (step_s) win_r <= win_nx_s;
      if (step_s && emit_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= win_nx_s;
        out_last_r  <= last_win_s;
      end else if (hs_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

`ifdef CONV_WIN_POS_EN
  logic [15:0] out_row_r, out_col_r;

  // Output-map coordinates of the window held in out_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_row_r <= 16'd0;
      out_col_r <= 16'd0;
    end else if (step_s && emit_s) begin
      out_row_r <= orow_s;
      out_col_r <= ocol_s;
    end
  end
  assign out_row = out_row_r;
  assign out_col = out_col_r;
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r != ST_IDLE);
  assign done      = last_hs_s;
endmodule

// File: tb/tb_conv_window_stream.sv
// tb_conv_window_stream: directed bench on a 4x4 image, K=3, P=1.
// Instance A: C=3, S=1 (16 windows). Instance B: C=1, S=2 (4 windows).
`timescale 1ns/1ps
module tb_conv_window_stream;
  localparam int W = 4, H = 4, K = 3, P = 1, DW = 8, CA = 3;
  localparam int AWID = DW * CA * K * K;
  localparam int BWID = DW * K * K;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic              a_out_last, a_busy, a_done;
  logic [DW*CA-1:0]  a_in_data;
  logic [AWID-1:0]   a_out_data;
  logic              b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic              b_out_last, b_busy, b_done;
  logic [DW-1:0]     b_in_data;
  logic [BWID-1:0]   b_out_data;
`ifdef CONV_WIN_POS_EN
  logic [15:0] a_out_row, a_out_col, b_out_row, b_out_col;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] first_c0 [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
  logic [7:0] last_c0  [9] = '{8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] b_win2   [9] = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8};

  conv_window_stream #(
    .pDATA_WIDTH(DW), .pIN_CHANNEL(CA), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
    .pKERNEL_SIZE(K), .pPADDING(P), .pSTRIDE(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .done(a_done)
`ifdef CONV_WIN_POS_EN
    , .out_row(a_out_row), .out_col(a_out_col)
`endif
  );

  conv_window_stream #(
    .pDATA_WIDTH(DW), .pIN_CHANNEL(1), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
    .pKERNEL_SIZE(K), .pPADDING(P), .pSTRIDE(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done)
`ifdef CONV_WIN_POS_EN
    , .out_row(b_out_row), .out_col(b_out_col)
`endif
  );

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Image pixel (r,c) channel ch; zero outside the image.
  function automatic logic [7:0] pix(input int r, input int c, input int ch);
    if (r < 0 || r >= H || c < 0 || c >= W) return 8'd0;
    return 8'(r * W + c + 1 + 16 * ch);
  endfunction

  function automatic logic [AWID-1:0] exp_a(input int orow, input int ocol);
    logic [AWID-1:0] w;
    w = '0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        for (int ch = 0; ch < CA; ch++)
          w[((kr*K+kc)*CA+ch)*DW +: DW] = pix(orow + kr - P, ocol + kc - P, ch);
    return w;
  endfunction

  function automatic logic [BWID-1:0] exp_b(input int orow, input int ocol);
    logic [BWID-1:0] w;
    w = '0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        w[(kr*K+kc)*DW +: DW] = pix(2*orow + kr - P, 2*ocol + kc - P, 0);
    return w;
  endfunction

  task automatic run_a(input bit bubbles, input int stall_win, input int stop_after);
    int win_idx, pix_idx, cyc, hold, done_cnt;
    bit stalled;
    logic [AWID-1:0] snap;
    win_idx = 0; pix_idx = 0; cyc = 0; hold = 0; done_cnt = 0; stalled = 1'b0; snap = '0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check_value("a_busy_start", a_busy, 1'b1);
    while (win_idx < stop_after && cyc < 1000) begin
      a_in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      a_in_data  = {pix(pix_idx / W, pix_idx % W, 2), pix(pix_idx / W, pix_idx % W, 1),
                    pix(pix_idx / W, pix_idx % W, 0)};
      if (!stalled && win_idx == stall_win && a_out_valid) begin
        stalled = 1'b1;
        hold    = 10;
        snap    = a_out_data;
      end
      a_out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        check_value("bp_valid", a_out_valid, 1'b1);
        check_value("bp_data", a_out_data, snap);
        check_value("bp_in_ready", a_in_ready, 1'b0);
        hold--;
      end
      if (a_done) done_cnt++;
      if (a_out_valid && a_out_ready) begin
        check_value("a_window", a_out_data, exp_a(win_idx / 4, win_idx % 4));
        check_value("a_last", a_out_last, win_idx == 15);
        check_value("a_done", a_done, win_idx == 15);
        if (win_idx == 0) begin
          for (int e = 0; e < 9; e++) check_value("a_first_win", a_out_data[e*CA*DW +: DW], first_c0[e]);
          check_value("a_ch2_el11", a_out_data[(4*CA+2)*DW +: DW], 8'd33);
        end
        if (win_idx == 15)
          for (int e = 0; e < 9; e++) check_value("a_last_win", a_out_data[e*CA*DW +: DW], last_c0[e]);
        win_idx++;
      end
      if (a_in_valid && a_in_ready) pix_idx++;
      @(negedge clk);
      cyc++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check_value("a_count", win_idx, stop_after);
    if (stop_after == 16) begin
      for (int i = 0; i < 20 && a_busy; i++) @(negedge clk);
      check_value("a_idle_after", a_busy, 1'b0);
      check_value("a_done_cnt", done_cnt, 1);
      check_value("a_pixels", pix_idx, 16);
    end else begin
      check_value("a_abort_no_done", done_cnt, 0);
    end
  endtask

  task automatic run_b();
    int win_idx, pix_idx, cyc, done_cnt;
    win_idx = 0; pix_idx = 0; cyc = 0; done_cnt = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (win_idx < 4 && cyc < 1000) begin
      b_in_valid  = 1'b1;
      b_in_data   = pix(pix_idx / W, pix_idx % W, 0);
      b_out_ready = 1'b1;
      #1;
      if (b_done) done_cnt++;
      if (b_out_valid && b_out_ready) begin
        check_value("b_window", b_out_data, exp_b(win_idx / 2, win_idx % 2));
        check_value("b_last", b_out_last, win_idx == 3);
        check_value("b_done", b_done, win_idx == 3);
        if (win_idx == 1)
          for (int e = 0; e < 9; e++) check_value("b_win2", b_out_data[e*DW +: DW], b_win2[e]);
        win_idx++;
      end
      if (b_in_valid && b_in_ready) pix_idx++;
      @(negedge clk);
      cyc++;
    end
    check_value("b_count", win_idx, 4);
    for (int i = 0; i < 20 && b_busy; i++) begin
      #1;
      if (b_done) done_cnt++;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    check_value("b_idle_after", b_busy, 1'b0);
    check_value("b_done_cnt", done_cnt, 1);
    check_value("b_pixels", pix_idx, 16);
  endtask

  initial begin
    rst = 1'b0;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #2;
    check_value("rst_out_valid", a_out_valid, 1'b0);
    check_value("rst_out_data", a_out_data, '0);
    check_value("rst_busy", a_busy, 1'b0);
    check_value("rst_in_ready", a_in_ready, 1'b0);
    check_value("rst_done", a_done, 1'b0);
    check_value("rst_b_out_valid", b_out_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_a(1'b0, -1, 16);
    run_a(1'b0, 5, 16);
    run_a(1'b1, -1, 16);
    run_b();

    run_a(1'b0, -1, 7);
    rst = 1'b0;
    #1;
    check_value("abort_out_valid", a_out_valid, 1'b0);
    check_value("abort_out_data", a_out_data, '0);
    check_value("abort_out_last", a_out_last, 1'b0);
    check_value("abort_busy", a_busy, 1'b0);
    check_value("abort_done", a_done, 1'b0);
    check_value("abort_in_ready", a_in_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_value("abort_stays_idle", a_busy, 1'b0);
    run_a(1'b0, -1, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
Streaming sliding-window generator for the next-generation convolution datapath. It accepts raster-order multi-channel pixels and inserts zero padding internally, so padding never consumes input. It emits complete K×K×C windows at stride S to the downstream PE array. Unlike the previous generation, both sides use full valid/ready handshakes with backpressure, and stride, padding, channel count and kernel size are all parametrised.

Parameters:
pDATA_WIDTH, 8, bits per channel sample
pIN_CHANNEL, 1, channels packed per pixel (C)
pINPUT_WIDTH, 28, image width W
pINPUT_HEIGHT, 28, image height H
pKERNEL_SIZE, 3, window side K (≥1)
pPADDING, 1, zero border P on every side (≥0)
pSTRIDE, 1, output stride S (≥1)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  begin a frame; sampled only in IDLE
in_valid  input  1  input pixel valid
in_data  input  pDATA_WIDTH*pIN_CHANNEL  pixel; channel c at [c*DW +: DW]
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  window valid
out_ready  input  1  downstream accepts window
out_data  output  pDATA_WIDTH*pIN_CHANNEL*K*K  window; element (kr,kc) at [(kr*K+kc)*DW*C +: DW*C], kr=0 is the top row, kc=0 is the left column
out_last  output  1  qualifies the final window of the frame
busy  output  1  frame in progress
done  output  1  one-cycle pulse when the final window is accepted

Behaviour:
- Definitions: Wp=W+2P, Hp=H+2P, OW=floor((Wp-K)/S)+1, OH=floor((Hp-K)/S)+1. Windows per frame = OW*OH.
- Reset (rst=0, asynchronous): state=IDLE. in_ready, out_valid, out_last, busy and done are all 0. out_data=0. Counters and window registers are cleared. Line buffer contents are don't-care.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE→SCAN on start. This clears the padded scan coordinates (pr,pc)=(0,0).
  - SCAN→DRAIN after step (Hp-1,Wp-1) completes.
  - DRAIN→IDLE when the final window handshakes (out_valid&&out_ready&&out_last). done pulses in that cycle.
  - start is ignored outside IDLE.
- Step: one advance of (pr,pc) in raster order over the padded grid.
  - Pad coordinate (pr<P, pr≥P+H, pc<P or pc≥P+W): the step pushes zeros and needs no input.
  - Interior coordinate: the step needs in_valid&&in_ready and pushes in_data.
  - in_ready = (state==SCAN) && coordinate is interior && !stall.
- stall = out_valid && !out_ready. While stalled, no step occurs and all state holds.
- Storage:
  - K-1 line buffers of depth Wp, each DW*C wide, implemented as circular RAM with a shared column pointer.
  - A K×K register window shifts left by one column per step. The new right column comes from the line buffers plus the pushed pixel.
- Emit: after the step at (pr,pc), a window is emitted if all of the following hold: pr≥K-1, pc≥K-1, (pr-K+1)%S==0, (pc-K+1)%S==0, (pc-K+1)/S<OW, (pr-K+1)/S<OH.
  - The emitted window has top-left at padded (pr-K+1, pc-K+1).
  - out_valid rises the cycle after the emitting step. out_data and out_last hold stable until the handshake.
  - A new emit may coincide with a handshake: back-to-back windows at one per cycle with no bubble.
- Throughput: one step per cycle when unstalled. Pad steps proceed even when in_valid=0.
- busy = state != IDLE.
- Reset mid-frame aborts immediately. No done is produced. The next frame requires a new start.
- Input pixels beyond W*H are never requested, because in_ready stays low.

Optional Feature:
Macro CONV_WIN_POS_EN.
- Defined: adds two output ports, out_row [15:0] and out_col [15:0]. They carry the output-map coordinates (0..OH-1, 0..OW-1) of the current window, are valid with out_valid, held under stall, and reset to 0.
- Undefined: the ports and their counters are absent. Behaviour is otherwise identical.

Test Plan:
- W=H=4, C=1, K=3, P=1, S=1; pixels 1..16, out_ready=1 → 16 windows. First window = {0,0,0, 0,1,2, 0,5,6}. Last window = {11,12,0, 15,16,0, 0,0,0} with out_last=1. done pulses once, same cycle as the last handshake.
- Same image with S=2 → OW=OH=2, so 4 windows with top-left padded (0,0),(0,2),(2,0),(2,2). Window 2 = {0,0,0, 2,3,4, 6,7,8}.
- Backpressure: out_ready=0 for 10 cycles mid-frame → out_data/out_valid stable, in_ready=0 throughout. After release, the full 16-window sequence matches the reference with none lost or duplicated.
- Input bubbles: in_valid toggles 1/0 randomly → identical window sequence. Pad steps advance without in_valid.
- C=3, DW=8, pixel p = {p+32, p+16, p} → every window element preserves channel packing. Channel 2 of element (1,1) in window 0 = 33.
- Assert rst=0 after 7 windows → all outputs 0 asynchronously. A new start replays the frame from window 0. No done from the aborted frame.
